// File: rtl/legv8_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : legv8_ctrl_pkg
// Purpose  : Shared types and encodings for the LEGv8 multicycle controller:
//            sequencer states, instruction classes, opcode patterns/masks,
//            sign-extender and ALU function encodings, static control word.
// Revision : 1.0 - initial release
// ============================================================================
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_LDUR = 3'd1,
    CLS_STUR = 3'd2,
    CLS_MOVZ = 3'd3,
    CLS_B    = 3'd4,
    CLS_CBZ  = 3'd5,
    CLS_NOP  = 3'd6
  } iclass_t;

  // Full 11-bit opcodes
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // Prefix-matched opcodes: low bits carry immediate/shift fields
  localparam logic [10:0] MASK_FULL = 11'b11111111111;
  localparam logic [10:0] MASK_B    = 11'b11111100000;
  localparam logic [10:0] PAT_B     = 11'b00010100000;
  localparam logic [10:0] MASK_CBZ  = 11'b11111111000;
  localparam logic [10:0] PAT_CBZ   = 11'b10110100000;
  localparam logic [10:0] MASK_MOVZ = 11'b11111111100;
  localparam logic [10:0] PAT_MOVZ  = 11'b11010010100;

  // Sign extender field select
  localparam logic [2:0] SIGN_I    = 3'd0;
  localparam logic [2:0] SIGN_D    = 3'd1;
  localparam logic [2:0] SIGN_B    = 3'd2;
  localparam logic [2:0] SIGN_CB   = 3'd3;
  localparam logic [2:0] SIGN_MOVZ = 3'd4;

  // ALU function codes
  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_ORR   = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_SUB   = 4'd6;
  localparam logic [3:0] ALU_PASSB = 4'd7;

  typedef struct packed {
    iclass_t    cls;
    logic       reg2loc;
    logic       alusrc;
    logic       mem2reg;
    logic [3:0] alu_op;
    logic [2:0] sign_op;
    logic       is_legal;
  } ctrl_word_t;

  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] mask,
                                    input logic [10:0] pat);
    return (op & mask) == pat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/legv8_multicycle_ctrl_opdecode.sv
`default_nettype none
// ============================================================================
// Module   : legv8_opdecode
// Purpose  : Combinational opcode classifier producing the static part of the
//            control word (selects that do not depend on the FSM state).
// Revision : 1.0 - initial release
// ============================================================================
module legv8_opdecode
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output ctrl_word_t  ctrl
);

  // Prefix-matched classes are tested first; none overlap the full opcodes
  always_comb begin
    ctrl          = '0;
    ctrl.cls      = CLS_NOP;
    ctrl.is_legal = 1'b1;
    if (op_match(opcode, MASK_B, PAT_B)) begin
      ctrl.cls     = CLS_B;
      ctrl.alu_op  = ALU_PASSB;
      ctrl.sign_op = SIGN_B;
    end else if (op_match(opcode, MASK_CBZ, PAT_CBZ)) begin
      ctrl.cls     = CLS_CBZ;
      ctrl.reg2loc = 1'b1;
      ctrl.alu_op  = ALU_PASSB;
      ctrl.sign_op = SIGN_CB;
    end else if (op_match(opcode, MASK_MOVZ, PAT_MOVZ)) begin
      ctrl.cls     = CLS_MOVZ;
      ctrl.alusrc  = 1'b1;
      ctrl.alu_op  = ALU_PASSB;
      ctrl.sign_op = SIGN_MOVZ;
    end else if (op_match(opcode, MASK_FULL, OP_LDUR)) begin
      ctrl.cls     = CLS_LDUR;
      ctrl.alusrc  = 1'b1;
      ctrl.mem2reg = 1'b1;
      ctrl.alu_op  = ALU_ADD;
      ctrl.sign_op = SIGN_D;
    end else if (op_match(opcode, MASK_FULL, OP_STUR)) begin
      ctrl.cls     = CLS_STUR;
      ctrl.reg2loc = 1'b1;
      ctrl.alusrc  = 1'b1;
      ctrl.alu_op  = ALU_ADD;
      ctrl.sign_op = SIGN_D;
    end else if (op_match(opcode, MASK_FULL, OP_ADD)) begin
      ctrl.cls    = CLS_R;
      ctrl.alu_op = ALU_ADD;
    end else if (op_match(opcode, MASK_FULL, OP_SUB)) begin
      ctrl.cls    = CLS_R;
      ctrl.alu_op = ALU_SUB;
    end else if (op_match(opcode, MASK_FULL, OP_AND)) begin
      ctrl.cls    = CLS_R;
      ctrl.alu_op = ALU_AND;
    end else if (op_match(opcode, MASK_FULL, OP_ORR)) begin
      ctrl.cls    = CLS_R;
      ctrl.alu_op = ALU_ORR;
    end else begin
      ctrl.is_legal = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/legv8_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : legv8_multicycle_ctrl
// Purpose  : Multicycle LEGv8 control sequencer. Fetches over a req/ready
//            handshake, decodes, and steps EXEC/MEM/WB driving all datapath
//            strobes. Memory waits are bounded by MAX_WAIT (sticky timeout).
// Options  : LEGV8_ILLEGAL_TRAP_EN - unrecognised opcodes trap to HALT and
//            raise illegal; otherwise they retire as a NOP.
// Revision : 1.0 - initial release
// ============================================================================
module legv8_multicycle_ctrl
  import legv8_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg2loc,
  output logic        alusrc,
  output logic        mem2reg,
  output logic        reg_write,
  output logic [3:0]  alu_op,
  output logic [2:0]  sign_op,
  output logic        mem_timeout,
  output logic        illegal
);

  localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  ctrl_word_t        cw;
  logic              stalled;
  logic              unused_operand_bits;

  // Operand fields belong to the datapath; only the opcode is decoded here
  assign unused_operand_bits = ^instr[20:0];

  legv8_opdecode u_opdecode (
    .opcode (instr[31:21]),
    .ctrl   (cw)
  );

  assign stalled = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;

  // State register
  always_ff @(posedge CLK) begin
    if (!resetl) state <= S_IDLE;
    else         state <= next_state;
  end

  // Wait counter: cleared on any state change, saturates at the limit
  always_ff @(posedge CLK) begin
    if (!resetl)                              wait_cnt <= '0;
    else if (next_state != state)             wait_cnt <= '0;
    else if (stalled && wait_cnt != WAIT_LIMIT) wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  // Sticky timeout: a ready arriving at the limit still counts as success
  always_ff @(posedge CLK) begin
    if (!resetl)                              mem_timeout <= 1'b0;
    else if (stalled && wait_cnt == WAIT_LIMIT) mem_timeout <= 1'b1;
  end

`ifdef LEGV8_ILLEGAL_TRAP_EN
  // Sticky illegal flag, raised on the way into HALT
  always_ff @(posedge CLK) begin
    if (!resetl)                                         illegal <= 1'b0;
    else if (state == S_DECODE && next_state == S_HALT) illegal <= 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

  // Next-state and strobe decode from state and instruction class
  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg2loc    = 1'b0;
    alusrc     = 1'b0;
    mem2reg    = 1'b0;
    reg_write  = 1'b0;
    alu_op     = '0;
    sign_op    = '0;
    if (state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      reg2loc = cw.reg2loc;
      alusrc  = cw.alusrc;
      alu_op  = cw.alu_op;
      sign_op = cw.sign_op;
    end
    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cw.is_legal) next_state = S_EXEC;
`ifdef LEGV8_ILLEGAL_TRAP_EN
        else             next_state = S_HALT;
`else
        else             next_state = S_WB;
`endif
      end
      S_EXEC: begin
        case (cw.cls)
          CLS_LDUR, CLS_STUR: next_state = S_MEM;
          CLS_B: begin
            pc_src     = 1'b1;
            pc_write   = 1'b1;
            next_state = S_FETCH;
          end
          CLS_CBZ: begin
            pc_src     = zero;
            pc_write   = 1'b1;
            next_state = S_FETCH;
          end
          default: next_state = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cw.cls == CLS_STUR);
        if (mem_ready) begin
          if (cw.cls == CLS_STUR) begin
            pc_write   = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write  = cw.is_legal;
        mem2reg    = (cw.cls == CLS_LDUR);
        pc_write   = 1'b1;
        next_state = S_FETCH;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_legv8_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_legv8_multicycle_ctrl
// Purpose  : Self-checking bench for legv8_multicycle_ctrl. A per-instruction
//            cycle model derived from the instruction class drives randomized
//            instructions and wait states and checks every strobe each cycle.
// Options  : honours LEGV8_ILLEGAL_TRAP_EN for the illegal-opcode scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_legv8_multicycle_ctrl;

  localparam int MAX_WAIT = 15;

  logic        CLK = 1'b0;
  logic        resetl = 1'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] ir = '0;
  logic [31:0] fetch_word = '0;
  logic        mem_req, mem_we, ir_write, pc_write, pc_src;
  logic        reg2loc, alusrc, mem2reg, reg_write;
  logic [3:0]  alu_op;
  logic [2:0]  sign_op;
  logic        mem_timeout, illegal;

  int   total = 0;
  int   passed = 0;
  logic sticky = 1'b0;
  logic ill_exp = 1'b0;

  legv8_multicycle_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .CLK         (CLK),
    .resetl      (resetl),
    .instr       (ir),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .reg2loc     (reg2loc),
    .alusrc      (alusrc),
    .mem2reg     (mem2reg),
    .reg_write   (reg_write),
    .alu_op      (alu_op),
    .sign_op     (sign_op),
    .mem_timeout (mem_timeout),
    .illegal     (illegal)
  );

  always #5 CLK = ~CLK;

  // Instruction register model: memory data captured on ir_write
  always @(posedge CLK) if (ir_write) ir <= fetch_word;

  // Class ids: 0 ADD 1 SUB 2 AND 3 ORR 4 LDUR 5 STUR 6 B 7 CBZ 8 MOVZ 9 unknown
  function automatic int classify(input logic [31:0] w);
    logic [10:0] op;
    op = w[31:21];
    if ((op >> 5) == 11'h005) return 6;
    if ((op >> 3) == 11'h0B4) return 7;
    if ((op >> 2) == 11'h1A5) return 8;
    case (op)
      11'b10001011000: return 0;
      11'b11001011000: return 1;
      11'b10001010000: return 2;
      11'b10101010000: return 3;
      11'b11111000010: return 4;
      11'b11111000000: return 5;
      default:         return 9;
    endcase
  endfunction

  function automatic logic [31:0] make_word(input int c);
    logic [31:0] r;
    r = $urandom;
    case (c)
      0: r[31:21] = 11'b10001011000;
      1: r[31:21] = 11'b11001011000;
      2: r[31:21] = 11'b10001010000;
      3: r[31:21] = 11'b10101010000;
      4: r[31:21] = 11'b11111000010;
      5: r[31:21] = 11'b11111000000;
      6: r[31:26] = 6'b000101;
      7: r[31:24] = 8'b10110100;
      8: r[31:23] = 9'b110100101;
      default: r[31:21] = 11'b00000000000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] exp_alu(input int c);
    case (c)
      0, 4, 5: return 32'd2;
      1:       return 32'd6;
      2:       return 32'd0;
      3:       return 32'd1;
      default: return 32'd7;
    endcase
  endfunction

  function automatic logic [31:0] v(input logic req, input logic we, input logic irw,
                                    input logic pcw, input logic pcs, input logic rw,
                                    input logic m2r, input logic to);
    return {24'b0, req, we, irw, pcw, pcs, rw, m2r, to};
  endfunction

  function automatic logic [31:0] obs();
    return v(mem_req, mem_we, ir_write, pc_write, pc_src, reg_write, mem2reg, mem_timeout);
  endfunction

  function automatic logic noise();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Drive mem_ready, then compare at the falling edge
  task automatic step(input string tag, input logic rdy, input logic [31:0] e, input int es);
    mem_ready = rdy;
    @(negedge CLK);
    chk(tag, obs(), e);
    chk({tag, "_illegal"}, {31'b0, illegal}, {31'b0, ill_exp});
    if (es >= 0) chk({tag, "_sign_op"}, {29'b0, sign_op}, 32'(es));
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    resetl    = 1'b0;
    mem_ready = noise();
    adv();
    sticky  = 1'b0;
    ill_exp = 1'b0;
    step("reset", noise(), v(0, 0, 0, 0, 0, 0, 0, 0), -1);
    adv();
    resetl = 1'b1;
    step("idle", noise(), v(0, 0, 0, 0, 0, 0, 0, 0), -1);
    adv();
  endtask

  // Runs one instruction from FETCH back to FETCH; fw/dw are memory wait cycles
  task automatic run_instr(input logic [31:0] word, input logic zval, input int fw,
                           input int dw, input bit abort);
    int       c;
    int       es;
    logic     last;
    c  = classify(word);
    es = (c == 4 || c == 5) ? 1 : (c == 6) ? 2 : (c == 7) ? 3 : (c == 8) ? 4 : -1;
    fetch_word = word;
    zero = noise();
    for (int j = 0; j <= fw; j++) begin
      last = (j == fw);
      step("fetch", last, v(1, 0, last, 0, 0, 0, 0, sticky | (j > MAX_WAIT)), -1);
      adv();
    end
    if (fw > MAX_WAIT) sticky = 1'b1;
    step("decode", noise(), v(0, 0, 0, 0, 0, 0, 0, sticky), es);
    adv();
    if (c == 9) begin
`ifdef LEGV8_ILLEGAL_TRAP_EN
      ill_exp = 1'b1;
      for (int k = 0; k < 20; k++) begin
        step("halt", noise(), v(0, 0, 0, 0, 0, 0, 0, sticky), -1);
        adv();
      end
      do_reset();
`else
      step("nop_wb", noise(), v(0, 0, 0, 1, 0, 0, 0, sticky), -1);
      adv();
`endif
      return;
    end
    zero = zval;
    if (c == 6)      step("exec_b", noise(), v(0, 0, 0, 1, 1, 0, 0, sticky), es);
    else if (c == 7) step("exec_cbz", noise(), v(0, 0, 0, 1, zval, 0, 0, sticky), es);
    else             step("exec", noise(), v(0, 0, 0, 0, 0, 0, 0, sticky), es);
    if (c <= 5 || c == 8) begin
      chk("alu_op", {28'b0, alu_op}, exp_alu(c));
      chk("alusrc", {31'b0, alusrc}, {31'b0, (c >= 4)});
    end
    if (c == 7) chk("reg2loc", {31'b0, reg2loc}, 32'd1);
    adv();
    if (c == 6 || c == 7) return;
    if (c == 4 || c == 5) begin
      for (int j = 0; j <= dw; j++) begin
        last = (j == dw);
        if (abort && j == 2) begin
          resetl = 1'b0;
          step("mem_rst", 1'b0, v(1, c == 5, 0, 0, 0, 0, 0, sticky), es);
          adv();
          sticky = 1'b0;
          step("rst_idle", 1'b0, v(0, 0, 0, 0, 0, 0, 0, 0), -1);
          adv();
          resetl = 1'b1;
          step("idle", noise(), v(0, 0, 0, 0, 0, 0, 0, 0), -1);
          adv();
          return;
        end
        step("mem", last, v(1, c == 5, 0, last && c == 5, 0, 0, 0, sticky | (j > MAX_WAIT)), es);
        adv();
      end
      if (dw > MAX_WAIT) sticky = 1'b1;
      if (c == 5) return;
    end
    step("wb", noise(), v(0, 0, 0, 1, 0, 1, c == 4, sticky), es);
    adv();
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    do_reset();
    run_instr(make_word(0), 1'b0, 0, 0, 1'b0);   // ADD, zero wait
    run_instr(make_word(4), 1'b0, 0, 3, 1'b0);   // LDUR, 3 data waits
    run_instr(make_word(7), 1'b1, 0, 0, 1'b0);   // CBZ taken
    run_instr(make_word(7), 1'b0, 0, 0, 1'b0);   // CBZ not taken
    for (int i = 0; i < 40; i++) begin
      c = $urandom_range(0, 8);
      run_instr(make_word(c), noise(), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end
    run_instr(make_word(2), 1'b0, 15, 0, 1'b0);  // ready exactly at the limit
    run_instr(make_word(5), 1'b0, 0, 15, 1'b0);  // data access at the limit
    run_instr(make_word(1), 1'b0, 16, 0, 1'b0);  // one past the limit: timeout
    run_instr(make_word(8), 1'b0, 0, 0, 1'b0);   // timeout stays set
    run_instr(make_word(4), 1'b0, 20, 17, 1'b0);
    do_reset();
    run_instr(make_word(4), 1'b0, 0, 5, 1'b1);   // reset mid data access
    run_instr(make_word(9), 1'b0, 0, 0, 1'b0);   // unrecognised opcode
    run_instr(make_word(0), 1'b0, 1, 0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
